// File: rtl/mux21_arbiter_pkg.sv
// Shared types and defaults for the two-requester round-robin channel arbiter.
package mux21_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/mux21_arbiter_if.sv
// Requester/consumer bundle shared by the arbiter and whatever surrounds it.
interface mux21_arbiter_if #(
    parameter int WIDTH = mux21_arbiter_pkg::DEF_WIDTH
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Handshake: a beat transfers on any rising clk edge where out_valid && out_ready.
    // While out_valid is high and out_ready low, out_data and the grant stay put.
    modport slave (
        input  req0, req1, data0, data1, out_ready,
        output gnt0, gnt1, sel, out_valid, out_data
    );

    modport master (
        output req0, req1, data0, data1, out_ready,
        input  gnt0, gnt1, sel, out_valid, out_data
    );
endinterface

// File: rtl/mux21_arbiter_bus.sv
// Bit-sliced 2:1 data multiplexer built from single-bit mux21 cells.
module mux21 (
    input  logic input1,
    input  logic input2,
    input  logic sel,
    output logic out
);
    assign out = sel ? input2 : input1;
endmodule

module mux21_bus #(
    parameter int WIDTH = mux21_arbiter_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        mux21 u_cell (
            .input1 (in1[i]),
            .input2 (in2[i]),
            .sel    (sel),
            .out    (out[i])
        );
    end
endmodule

// File: rtl/mux21_arbiter.sv
// Round-robin arbiter sharing one valid/ready output between two requesters,
// with a per-grant burst limit that only forces hand-over under contention.
module mux21_arbiter
    import mux21_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mux21_arbiter_if.slave              bus,
    output state_e                      dbg_state,
    output logic [$clog2(MAX_BURST):0]  dbg_beat_cnt,
    output logic                        dbg_last
);
    localparam int              CNT_W    = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             last_q, last_d;

    logic             gnt0, gnt1, sel, out_valid, beat;
    logic             is_idle, own_req, oth_req, own_id;
    state_e           oth_st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
        end
    end

    // Fold G0/G1 into one "own vs other" view so both grants share the same rules.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        last_d     = last_q;
        is_idle    = 1'b0;
        own_req    = 1'b0;
        oth_req    = 1'b0;
        own_id     = 1'b0;
        oth_st     = ST_IDLE;
        case (state_q)
            ST_G0: begin
                own_req = bus.req0;
                oth_req = bus.req1;
                own_id  = 1'b0;
                oth_st  = ST_G1;
            end
            ST_G1: begin
                own_req = bus.req1;
                oth_req = bus.req0;
                own_id  = 1'b1;
                oth_st  = ST_G0;
            end
            default: is_idle = 1'b1;
        endcase

        if (is_idle) begin
            beat_cnt_d = '0;
            if (bus.req0 && bus.req1) state_d = last_q ? ST_G0 : ST_G1;
            else if (bus.req0)        state_d = ST_G0;
            else if (bus.req1)        state_d = ST_G1;
            else                      state_d = ST_IDLE;
        end else if (!own_req) begin
            state_d    = oth_req ? oth_st : ST_IDLE;
            last_d     = own_id;
            beat_cnt_d = '0;
        end else if (beat) begin
            if (beat_cnt_q == CNT_LAST) begin
                beat_cnt_d = '0;
                if (oth_req) begin
                    state_d = oth_st;
                    last_d  = own_id;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        gnt0      = (state_q == ST_G0);
        gnt1      = (state_q == ST_G1);
        sel       = gnt1;
        out_valid = (gnt0 && bus.req0) || (gnt1 && bus.req1);
        beat      = out_valid && bus.out_ready;
    end

    mux21_bus #(.WIDTH(WIDTH)) u_bus (
        .in1 (bus.data0),
        .in2 (bus.data1),
        .sel (sel),
        .out (bus.out_data)
    );

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.sel       = sel;
    assign bus.out_valid = out_valid;

    assign dbg_state    = state_q;
    assign dbg_beat_cnt = beat_cnt_q;
    assign dbg_last     = last_q;

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed bench for mux21_arbiter: vector table for steady-state arbitration plus
// hand-written backpressure, early-release, async-reset and MAX_BURST=1 sequences.
module tb_mux21_arbiter;
    import mux21_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic sb_on;
    logic [7:0] exp_q[$];

    mux21_arbiter_if #(.WIDTH(8)) bus ();
    mux21_arbiter_if #(.WIDTH(8)) bus2 ();

    state_e     st_a, st_b;
    logic [2:0] cnt_a;
    logic [0:0] cnt_b;
    logic       last_a, last_b;

    mux21_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .dbg_state    (st_a),
        .dbg_beat_cnt (cnt_a),
        .dbg_last     (last_a)
    );

    mux21_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus2.slave),
        .dbg_state    (st_b),
        .dbg_beat_cnt (cnt_b),
        .dbg_last     (last_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic       g0;
        logic       g1;
        logic       sel;
        logic       vld;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic g0, input logic g1,
                           input logic s, input logic v, input logic [7:0] d);
        chk({tag, "_gnt0"},  32'(bus.gnt0),      32'(g0));
        chk({tag, "_gnt1"},  32'(bus.gnt1),      32'(g1));
        chk({tag, "_sel"},   32'(bus.sel),       32'(s));
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    endtask

    // driver: apply inputs on the falling edge, settle, then let the caller check
    task automatic step(input logic r0, input logic r1, input logic [7:0] d0,
                        input logic [7:0] d1, input logic rdy);
        @(negedge clk);
        bus.req0      = r0;
        bus.req1      = r1;
        bus.data0     = d0;
        bus.data1     = d1;
        bus.out_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // scoreboard: every accepted beat must match the next expected data word
    always @(negedge clk) begin
        #2;
        if (sb_on && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_beat: got unexpected beat data %0h, expected no beat", bus.out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    bad++;
                    $display("FAIL sb_beat: got %0h expected %0h", bus.out_data, e);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        sb_on = 1'b0;
        rst_n = 1'b0;
        bus.req0 = 1'b1;  bus.req1 = 1'b1;
        bus.data0 = 8'h00; bus.data1 = 8'h00; bus.out_ready = 1'b0;
        bus2.req0 = 1'b0; bus2.req1 = 1'b0;
        bus2.data0 = 8'h00; bus2.data1 = 8'h00; bus2.out_ready = 1'b0;

        // fields: r0 r1 d0 d1 rdy | g0 g1 sel vld dat
        tbl[0]  = '{1'b0, 1'b1, 8'h3C, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[1]  = '{1'b0, 1'b1, 8'h3C, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
        tbl[2]  = '{1'b0, 1'b1, 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A};
        tbl[3]  = '{1'b0, 1'b1, 8'h3C, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[4]  = '{1'b0, 1'b1, 8'h3C, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[5]  = '{1'b0, 1'b1, 8'h3C, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33};
        tbl[6]  = '{1'b0, 1'b1, 8'h3C, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44};
        tbl[7]  = '{1'b0, 1'b0, 8'h3C, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77};
        tbl[8]  = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        tbl[9]  = '{1'b1, 1'b1, 8'h10, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10};
        tbl[10] = '{1'b1, 1'b1, 8'h11, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[11] = '{1'b1, 1'b1, 8'h12, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12};
        tbl[12] = '{1'b1, 1'b1, 8'h13, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13};
        tbl[13] = '{1'b1, 1'b1, 8'h20, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hE0};
        tbl[14] = '{1'b1, 1'b1, 8'h20, 8'hE1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hE1};
        tbl[15] = '{1'b1, 1'b1, 8'h20, 8'hE2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hE2};
        tbl[16] = '{1'b1, 1'b1, 8'h20, 8'hE3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hE3};
        tbl[17] = '{1'b1, 1'b1, 8'h30, 8'hD0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30};

        // reset held with both requests pending
        repeat (2) @(negedge clk);
        #1;
        chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_last", 32'(last_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("rel_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        chk_out("rel_g0", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // single requester, contention and zero-bubble hand-over
        do_reset();
        sb_on = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].vld && tbl[i].rdy) exp_q.push_back(tbl[i].dat);
            step(tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1, tbl[i].rdy);
            chk_out($sformatf("v%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].sel, tbl[i].vld, tbl[i].dat);
        end
        #2;
        sb_on = 1'b0;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // backpressure on the final beat of a G0 burst
        step(1'b1, 1'b1, 8'h40, 8'hC0, 1'b1);
        step(1'b1, 1'b1, 8'h40, 8'hC0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 8'h40, 8'hC0, 1'b0);
            chk_out($sformatf("bp%0d", k), 1'b1, 1'b0, 1'b0, 1'b1, 8'h40);
            chk($sformatf("bp%0d_cnt", k), 32'(cnt_a), 32'd3);
        end
        step(1'b1, 1'b1, 8'h40, 8'hC0, 1'b1);
        chk_out("bp_beat", 1'b1, 1'b0, 1'b0, 1'b1, 8'h40);
        step(1'b1, 1'b1, 8'h40, 8'hC0, 1'b1);
        chk_out("bp_g1", 1'b0, 1'b1, 1'b1, 1'b1, 8'hC0);

        // early release of G1 after two beats
        step(1'b1, 1'b1, 8'h40, 8'hC1, 1'b1);
        chk_out("er_b2", 1'b0, 1'b1, 1'b1, 1'b1, 8'hC1);
        step(1'b1, 1'b0, 8'h41, 8'hC2, 1'b1);
        chk_out("er_drop", 1'b0, 1'b1, 1'b1, 1'b0, 8'hC2);
        chk("er_drop_cnt", 32'(cnt_a), 32'd2);
        step(1'b1, 1'b0, 8'h42, 8'hC3, 1'b1);
        chk_out("er_g0", 1'b1, 1'b0, 1'b0, 1'b1, 8'h42);
        chk("er_g0_cnt", 32'(cnt_a), 32'd0);
        chk("er_g0_state", 32'(st_a), 32'(ST_G0));

        // async reset between edges while G1 is streaming
        step(1'b0, 1'b1, 8'h50, 8'hB0, 1'b1);
        chk_out("ar_rel0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h50);
        step(1'b0, 1'b1, 8'h50, 8'hB1, 1'b1);
        chk_out("ar_g1", 1'b0, 1'b1, 1'b1, 1'b1, 8'hB1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt1", 32'(bus.gnt1), 32'd0);
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_sel", 32'(bus.sel), 32'd0);
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ar_state", 32'(st_a), 32'(ST_IDLE));
        chk("ar_last", 32'(last_a), 32'd1);
        chk("ar_cnt", 32'(cnt_a), 32'd0);
        step(1'b1, 1'b1, 8'h60, 8'hA0, 1'b1);
        chk_out("ar_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h60);
        step(1'b1, 1'b1, 8'h60, 8'hA0, 1'b1);
        chk_out("ar_g0", 1'b1, 1'b0, 1'b0, 1'b1, 8'h60);

        // MAX_BURST=1 instance alternates every beat under contention
        @(negedge clk);
        bus2.req0 = 1'b1; bus2.req1 = 1'b1;
        bus2.data0 = 8'hAA; bus2.data1 = 8'hBB; bus2.out_ready = 1'b1;
        #1;
        chk("mb1_idle_g0", 32'(bus2.gnt0), 32'd0);
        chk("mb1_idle_g1", 32'(bus2.gnt1), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mb1_%0d_g0", k), 32'(bus2.gnt0), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("mb1_%0d_g1", k), 32'(bus2.gnt1), (k % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("mb1_%0d_data", k), 32'(bus2.out_data), (k % 2 == 0) ? 32'hAA : 32'hBB);
        end

        // report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
